// File: rtl/pulse_measure_pkg.sv
// Shared types, FSM encoding and default 100 ms-class timing constants for the pulse meter.
package pulse_measure_pkg;

    localparam int unsigned CNT_W = 21;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    localparam cnt_t T100MS_PERIOD  = 21'd2_000_001;
    localparam cnt_t T100MS_WIDTH   = 21'd500_000;
    localparam cnt_t T100MS_TOL     = 21'd16;
    localparam cnt_t T100MS_TIMEOUT = 21'd2_097_151;

    // Unsigned |meas - ref_val| <= tol, ordered subtract so nothing wraps.
    function automatic logic within_tol(cnt_t meas, cnt_t ref_val, cnt_t tol);
        cnt_t diff;
        diff = (meas >= ref_val) ? (meas - ref_val) : (ref_val - meas);
        return diff <= tol;
    endfunction

endpackage

// File: rtl/pulse_measure_module_sync_edge_detect.sv
// Two-flop synchronizer plus previous-value register; emits registered one-cycle rise/fall strobes.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic sync1_q, sync2_q, prev_q;
    logic rise_q, fall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            rise_q  <= sync2_q & ~prev_q;
            fall_q  <= ~sync2_q & prev_q;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/pulse_measure_module.sv
// Measures rise-to-rise period and high time of Pulse_In in CLK cycles, flags tolerance match
// and loss of signal.
module pulse_measure_module
    import pulse_measure_pkg::*;
#(
    parameter cnt_t T_EXP_PERIOD = T100MS_PERIOD,
    parameter cnt_t T_EXP_WIDTH  = T100MS_WIDTH,
    parameter cnt_t T_TOL        = T100MS_TOL,
    parameter cnt_t T_TIMEOUT    = T100MS_TIMEOUT
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             Pulse_In,
    output logic [CNT_W-1:0] Period_Out,
    output logic [CNT_W-1:0] Width_Out,
    output logic             Valid_Out,
    output logic             Match_Out,
    output logic             Timeout_Out
);

    logic   rise, fall;
    state_t state_q, state_d;
    cnt_t   count_q, count_d, count_inc;
    cnt_t   width_q, width_d;
    cnt_t   period_out_q, period_out_d;
    cnt_t   width_out_q, width_out_d;
    logic   valid_q, valid_d;
    logic   match_q, match_d;
    logic   timeout_q, timeout_d;

    sync_edge_detect u_sync_edge_detect (
        .clk   (CLK),
        .rst_n (RST_n),
        .din   (Pulse_In),
        .rise  (rise),
        .fall  (fall)
    );

    // Saturating increment: a fall exactly at the timeout bound must not wrap the counter.
    assign count_inc = (count_q == '1) ? count_q : count_q + cnt_t'(1);

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        width_d      = width_q;
        period_out_d = period_out_q;
        width_out_d  = width_out_q;
        valid_d      = 1'b0;
        match_d      = match_q;
        timeout_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_HIGH;
                    count_d = cnt_t'(1);
                end
            end
            S_HIGH: begin
                if (fall) begin
                    state_d = S_LOW;
                    width_d = count_q;
                    count_d = count_inc;
                end else if (count_q >= T_TIMEOUT) begin
                    state_d   = S_IDLE;
                    count_d   = '0;
                    timeout_d = 1'b1;
                    match_d   = 1'b0;
                end else begin
                    count_d = count_inc;
                end
            end
            S_LOW: begin
                if (rise) begin
                    state_d      = S_HIGH;
                    period_out_d = count_q;
                    width_out_d  = width_q;
                    count_d      = cnt_t'(1);
                    valid_d      = 1'b1;
                    match_d      = within_tol(count_q, T_EXP_PERIOD, T_TOL) &&
                                   within_tol(width_q, T_EXP_WIDTH, T_TOL);
                end else if (count_q >= T_TIMEOUT) begin
                    state_d   = S_IDLE;
                    count_d   = '0;
                    timeout_d = 1'b1;
                    match_d   = 1'b0;
                end else begin
                    count_d = count_inc;
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            width_q      <= '0;
            period_out_q <= '0;
            width_out_q  <= '0;
            valid_q      <= 1'b0;
            match_q      <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            width_q      <= width_d;
            period_out_q <= period_out_d;
            width_out_q  <= width_out_d;
            valid_q      <= valid_d;
            match_q      <= match_d;
            timeout_q    <= timeout_d;
        end
    end

    assign Period_Out  = period_out_q;
    assign Width_Out   = width_out_q;
    assign Valid_Out   = valid_q;
    assign Match_Out   = match_q;
    assign Timeout_Out = timeout_q;

endmodule

// File: tb/tb_pulse_measure_module.sv
// Self-checking bench: drives pulse trains, predicts report/timeout events from edge times.
module tb_pulse_measure_module;

    localparam int EP  = 100;
    localparam int EW  = 25;
    localparam int TOL = 2;
    localparam int TO  = 200;

    logic        CLK = 1'b0;
    logic        RST_n;
    logic        Pulse_In;
    logic [20:0] Period_Out;
    logic [20:0] Width_Out;
    logic        Valid_Out;
    logic        Match_Out;
    logic        Timeout_Out;

    typedef struct {
        int cyc;
        bit is_to;
        int p;
        int w;
        bit m;
    } ev_t;

    ev_t obs_q[$];
    ev_t exp_q[$];
    int  rise_q[$];
    int  fall_q[$];
    int  cyc   = 0;
    int  total = 0;
    int  bad   = 0;

    pulse_measure_module #(
        .T_EXP_PERIOD (21'd100),
        .T_EXP_WIDTH  (21'd25),
        .T_TOL        (21'd2),
        .T_TIMEOUT    (21'd200)
    ) dut (
        .CLK         (CLK),
        .RST_n       (RST_n),
        .Pulse_In    (Pulse_In),
        .Period_Out  (Period_Out),
        .Width_Out   (Width_Out),
        .Valid_Out   (Valid_Out),
        .Match_Out   (Match_Out),
        .Timeout_Out (Timeout_Out)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_eq(string tag, longint got, longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, want, cyc);
        end
    endtask

    // Record every strobe seen; cyc == k means the window between edge k and edge k+1.
    always @(negedge CLK) begin
        ev_t e;
        if (Valid_Out || Timeout_Out) begin
            e.cyc   = cyc;
            e.is_to = Timeout_Out;
            e.p     = int'(Period_Out);
            e.w     = int'(Width_Out);
            e.m     = Match_Out;
            obs_q.push_back(e);
            check_eq("valid_timeout_excl", longint'(Valid_Out & Timeout_Out), 0);
        end
    end

    function automatic bit in_tol(int a, int b);
        return ((a > b) ? a - b : b - a) <= TOL;
    endfunction

    // Reference: a rise sampled at edge R is reported 3 edges later; the first rise after
    // reset/timeout only arms; a gap above TO declares loss of signal TO+3 edges after it.
    task automatic build_expected(int end_cyc);
        int  last;
        int  lp;
        int  lw;
        bit  armed;
        ev_t e;
        last  = 0;
        lp    = 0;
        lw    = 0;
        armed = 1'b0;
        exp_q.delete();
        foreach (rise_q[i]) begin
            if (!armed) begin
                armed = 1'b1;
                last  = rise_q[i];
                continue;
            end
            if (rise_q[i] - last > TO) begin
                e.cyc = last + TO + 3; e.is_to = 1'b1; e.p = lp; e.w = lw; e.m = 1'b0;
                if (e.cyc <= end_cyc) exp_q.push_back(e);
                last = rise_q[i];
                continue;
            end
            e.cyc   = rise_q[i] + 3;
            e.is_to = 1'b0;
            e.p     = rise_q[i] - last;
            e.w     = fall_q[i-1] - last;
            e.m     = in_tol(e.p, EP) && in_tol(e.w, EW);
            if (e.cyc <= end_cyc) exp_q.push_back(e);
            lp   = e.p;
            lw   = e.w;
            last = rise_q[i];
        end
        if (armed) begin
            e.cyc = last + TO + 3; e.is_to = 1'b1; e.p = lp; e.w = lw; e.m = 1'b0;
            if (e.cyc <= end_cyc) exp_q.push_back(e);
        end
    endtask

    task automatic compare(string tag, int end_cyc);
        build_expected(end_cyc);
        check_eq({tag, ".events"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            check_eq({tag, ".cyc"},     obs_q[i].cyc,   exp_q[i].cyc);
            check_eq({tag, ".timeout"}, obs_q[i].is_to, exp_q[i].is_to);
            check_eq({tag, ".period"},  obs_q[i].p,     exp_q[i].p);
            check_eq({tag, ".width"},   obs_q[i].w,     exp_q[i].w);
            check_eq({tag, ".match"},   obs_q[i].m,     exp_q[i].m);
        end
        obs_q.delete();
        rise_q.delete();
        fall_q.delete();
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Pulse_In changes 1 time unit after an edge, so the next edge (cyc+1) samples it.
    task automatic drive_pulse(int hi, int lo);
        Pulse_In = 1'b1;
        rise_q.push_back(cyc + 1);
        repeat (hi) step();
        Pulse_In = 1'b0;
        fall_q.push_back(cyc + 1);
        repeat (lo) step();
    endtask

    task automatic do_reset();
        Pulse_In = 1'b0;
        RST_n    = 1'b0;
        step();
        step();
        RST_n = 1'b1;
        obs_q.delete();
        rise_q.delete();
        fall_q.delete();
    endtask

    task automatic tail();
        repeat (TO + 20) step();
    endtask

    task automatic check_all_zero(string tag);
        check_eq({tag, ".period"},  Period_Out,  0);
        check_eq({tag, ".width"},   Width_Out,   0);
        check_eq({tag, ".valid"},   Valid_Out,   0);
        check_eq({tag, ".match"},   Match_Out,   0);
        check_eq({tag, ".timeout"}, Timeout_Out, 0);
    endtask

    initial begin
        int c;
        int p;
        int w;
        RST_n    = 1'b0;
        Pulse_In = 1'b0;
        step();
        step();
        check_all_zero("reset");

        // Out-of-tolerance period 103, then matching period 102, then loss of signal.
        do_reset();
        repeat (4) drive_pulse(25, 78);
        repeat (4) drive_pulse(25, 77);
        tail();
        compare("scaled", cyc - 1);

        // Narrowest legal pulse: high 1 cycle, period 4.
        do_reset();
        repeat (6) drive_pulse(1, 3);
        tail();
        compare("narrow", cyc - 1);

        // One-cycle reset in the low phase discards the running measurement.
        do_reset();
        repeat (3) drive_pulse(25, 75);
        repeat (10) step();
        c     = cyc;
        RST_n = 1'b0;
        step();
        check_all_zero("mid_reset");
        compare("pre_reset", c);
        RST_n = 1'b1;
        repeat (3) drive_pulse(25, 75);
        tail();
        compare("post_reset", cyc - 1);

        // Random trains mixing near-nominal pulses with wide-range periods and dropouts.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int k = 0; k < 12; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    p = int'($urandom_range(97, 104));
                    w = int'($urandom_range(22, 28));
                end else begin
                    p = int'($urandom_range(4, 260));
                    w = int'($urandom_range(1, (p - 1 < TO - 1) ? p - 1 : TO - 1));
                end
                drive_pulse(w, p - w);
            end
            tail();
            compare("random", cyc - 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pulse_measure_module.md
PULSE_MEASURE_MODULE -- requirements
Module: pulse_measure_module

Interface
REQ-001 Parameter T_EXP_PERIOD, default 21'd2_000_001, expected cycles between consecutive rising edges.
REQ-002 Parameter T_EXP_WIDTH, default 21'd500_000, expected high-time cycles.
REQ-003 Parameter T_TOL, default 21'd16, allowed ± deviation for period and width match.
REQ-004 Parameter T_TIMEOUT, default 21'd2_097_151, cycle count without an edge that declares loss of signal.
REQ-005 CLK  input  1  single system clock, rising-edge.
REQ-006 RST_n  input  1  synchronous, active-low reset, sampled on CLK rising edge.
REQ-007 Pulse_In  input  1  asynchronous periodic pulse (LED-style timing output) to be measured.
REQ-008 Period_Out  output  21  last measured rise-to-rise interval in CLK cycles.
REQ-009 Width_Out  output  21  last measured rise-to-fall high time in CLK cycles.
REQ-010 Valid_Out  output  1  one-cycle strobe: Period_Out/Width_Out/Match_Out updated.
REQ-011 Match_Out  output  1  both measurements within T_TOL of expected values.
REQ-012 Timeout_Out  output  1  one-cycle strobe: no edge for T_TIMEOUT cycles.

Function
REQ-013 Pulse_In SHALL pass a 2-flop synchronizer; a third register holds the previous synchronized value for edge detection.
REQ-014 Rise detect SHALL be sync=1, prev=0; fall detect SHALL be sync=0, prev=1; at most one per cycle.
REQ-015 FSM states: S_IDLE (await first rise), S_HIGH (counting high phase), S_LOW (counting low phase).
REQ-016 S_IDLE: on rise -> S_HIGH, Count<=1; no Valid_Out; all other inputs ignored.
REQ-017 S_HIGH: Count increments each cycle; on fall -> S_LOW, internal width register <= Count.
REQ-018 S_LOW: Count increments; on rise -> S_HIGH, Period_Out<=Count, Width_Out<=width register, Count<=1, Valid_Out=1 next cycle.
REQ-019 Measurement latency: Valid_Out SHALL assert exactly 1 cycle after the rise-detect cycle (4 cycles after Pulse_In rises synchronously before a CLK edge).
REQ-020 Match_Out SHALL update with Valid_Out: 1 iff |Period−T_EXP_PERIOD|<=T_TOL and |Width−T_EXP_WIDTH|<=T_TOL, using unsigned compare-and-subtract (no signed wrap); held until next Valid_Out or timeout.
REQ-021 Count SHALL never wrap; when Count==T_TIMEOUT in S_HIGH or S_LOW, Timeout_Out=1 for one cycle, FSM -> S_IDLE, Match_Out<=0, Period_Out/Width_Out retain last values.
REQ-022 Timeout and edge in same cycle: edge SHALL take precedence, no Timeout_Out.
REQ-023 Valid_Out and Timeout_Out SHALL never be high in the same cycle.
REQ-024 First period after S_IDLE SHALL NOT be reported (partial measurement discarded).

Reset
REQ-025 RST_n=0 at a CLK edge: FSM=S_IDLE, synchronizer/prev regs=0, Count=0, Period_Out=0, Width_Out=0, Valid_Out=0, Match_Out=0, Timeout_Out=0.
REQ-026 Reset mid-measurement SHALL discard the partial measurement; first reported period requires two rises after RST_n returns high.
REQ-027 No asynchronous reset path SHALL exist.

Structure
REQ-028 Shared package SHALL hold FSM state encoding (S_IDLE=2'd0, S_HIGH=2'd1, S_LOW=2'd2) and default timing constants (T100MS-family values, width 21).
REQ-029 One sub-module natural: sync_edge_detect (2-flop sync + rise/fall strobes); counter, FSM and compare stay in top.

Verification
REQ-030 Reset, then Pulse_In period 2_000_001, high 500_000 -> from second rise on, Valid_Out every 2_000_001 cycles, Period_Out=2_000_001, Width_Out=500_000, Match_Out=1.
REQ-031 Parameters scaled (T_EXP_PERIOD=100, T_EXP_WIDTH=25, T_TOL=2), stimulus period 103, high 25 -> Period_Out=103, Match_Out=0; period 102 -> Match_Out=1.
REQ-032 Pulse_In held 0 after running (T_TIMEOUT=200) -> Timeout_Out single pulse 200 cycles after last rise count start, Match_Out=0, Period_Out unchanged, no Valid_Out.
REQ-033 RST_n low for 1 cycle in mid S_LOW -> all outputs 0 next cycle; next Valid_Out only after second subsequent rise.
REQ-034 Pulse_In toggling high 1 cycle, period 4 -> Width_Out=1, Period_Out=4, Valid_Out each period, no missed edges.
